// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch time core.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_t;

  // MM:SS as four BCD digits, most significant first
  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } sw_time_t;

  localparam bcd_t SEC_ONES_MAX = BCD_W'(9);
  localparam bcd_t SEC_TENS_MAX = BCD_W'(5);
  localparam bcd_t MIN_ONES_MAX = BCD_W'(9);
  localparam bcd_t MIN_TENS_MAX = BCD_W'(5);

endpackage

// File: rtl/stopwatch_time_core_bcd_digit_step.sv
// One BCD digit incrementer/decrementer with carry/borrow out; chained 4x.
module bcd_digit_step
  import stopwatch_pkg::*;
(
  input  bcd_t digit,
  input  bcd_t max,
  input  logic en,
  input  logic down,
  output bcd_t next_digit_c,
  output logic carry_c
);

  // Step the digit, wrapping at 0/max and flagging carry or borrow
  always_comb begin
    next_digit_c = digit;
    carry_c      = 1'b0;
    if (en) begin
      if (down) begin
        if (digit == '0) begin
          next_digit_c = max;
          carry_c      = 1'b1;
        end else begin
          next_digit_c = digit - BCD_W'(1);
        end
      end else begin
        if (digit >= max) begin
          next_digit_c = '0;
          carry_c      = 1'b1;
        end else begin
          next_digit_c = digit + BCD_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_time_core.sv
// MM:SS stopwatch time register with run/pause/done control.
module stopwatch_time_core
  import stopwatch_pkg::*;
#(
  parameter bit DOWN_STOP_AT_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       dir,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       done
);

  sw_state_t  state_q, state_d;
  sw_time_t   time_q, time_d;
  sw_time_t   chain_c;
  logic [3:0] cy_c;
  logic       dir_q, dir_d;
  logic       done_q, done_d;
  logic       running_q;
  logic       step_en_c;
  logic       adj_en_c;
  logic       step_down_c;

  // The digit chain serves both the 1 Hz step in RUN and the minute adjust in IDLE
  assign step_en_c   = (state_q == RUN) && tick;
  assign adj_en_c    = (state_q == IDLE) && !start_stop && (inc ^ dec);
  assign step_down_c = (state_q == RUN) ? dir_q : dec;

  bcd_digit_step u_sec_ones (
    .digit(time_q.sec_ones), .max(SEC_ONES_MAX), .en(step_en_c),
    .down(step_down_c), .next_digit_c(chain_c.sec_ones), .carry_c(cy_c[0])
  );
  bcd_digit_step u_sec_tens (
    .digit(time_q.sec_tens), .max(SEC_TENS_MAX), .en(cy_c[0]),
    .down(step_down_c), .next_digit_c(chain_c.sec_tens), .carry_c(cy_c[1])
  );
  bcd_digit_step u_min_ones (
    .digit(time_q.min_ones), .max(MIN_ONES_MAX), .en(cy_c[1] | adj_en_c),
    .down(step_down_c), .next_digit_c(chain_c.min_ones), .carry_c(cy_c[2])
  );
  bcd_digit_step u_min_tens (
    .digit(time_q.min_tens), .max(MIN_TENS_MAX), .en(cy_c[2]),
    .down(step_down_c), .next_digit_c(chain_c.min_tens), .carry_c(cy_c[3])
  );

  // Next-state, time and done logic; clear > tick > start_stop > inc/dec
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      time_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_stop) begin
            // a down-count from 00:00 has nothing to count
            if (!(dir && (time_q == '0))) begin
              dir_d   = dir;
              state_d = RUN;
            end
          end else if (adj_en_c) begin
            time_d = chain_c;
          end
        end
        RUN: begin
          if (tick) begin
            time_d = chain_c;
            if (!dir_q) begin
              done_d = cy_c[3];
            end else if (chain_c == '0) begin
              done_d = 1'b1;
              if (DOWN_STOP_AT_ZERO) state_d = DONE;
            end
          end
          if (start_stop && (state_d == RUN)) state_d = PAUSE;
        end
        PAUSE: begin
          if (start_stop) state_d = RUN;
        end
        DONE: begin
          if (start_stop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, direction latch, digit and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      time_q    <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
    end
  end

  assign sec_ones = time_q.sec_ones;
  assign sec_tens = time_q.sec_tens;
  assign min_ones = time_q.min_ones;
  assign min_tens = time_q.min_tens;
  assign running  = running_q;
  assign done     = done_q;

endmodule

// File: tb/tb_stopwatch_time_core.sv
// Randomized and directed bench for stopwatch_time_core against a seconds-count model.
module tb_stopwatch_time_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, start_stop = 1'b0, clear = 1'b0, dir = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [3:0] so0, st0, mo0, mt0, so1, st1, mo1, mt1;
  logic run0, done0, run1, done1;
  logic [15:0] d0, d1;

  assign d0 = {mt0, mo0, st0, so0};
  assign d1 = {mt1, mo1, st1, so1};

  always #5 clk = ~clk;

  stopwatch_time_core dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear),
    .dir(dir), .inc(inc), .dec(dec), .sec_ones(so0), .sec_tens(st0),
    .min_ones(mo0), .min_tens(mt0), .running(run0), .done(done0)
  );

  stopwatch_time_core #(.DOWN_STOP_AT_ZERO(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear),
    .dir(dir), .inc(inc), .dec(dec), .sec_ones(so1), .sec_tens(st1),
    .min_ones(mo1), .min_tens(mt1), .running(run1), .done(done1)
  );

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  // model: time as total seconds 0..3599, index 0 = stop-at-zero, 1 = wrap
  int m_t[2];
  int m_st[2];
  bit m_dq[2];
  bit m_dn[2];

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [15:0] exp_dig(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_st[i] = M_IDLE; m_dq[i] = 1'b0; m_dn[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    int m, s;
    for (int i = 0; i < 2; i++) begin
      m_dn[i] = 1'b0;
      if (clear) begin
        m_t[i] = 0;
        m_st[i] = M_IDLE;
      end else begin
        case (m_st[i])
          M_IDLE: begin
            if (start_stop) begin
              if (!(dir && m_t[i] == 0)) begin
                m_dq[i] = dir;
                m_st[i] = M_RUN;
              end
            end else if (inc != dec) begin
              m = m_t[i] / 60;
              s = m_t[i] % 60;
              m = inc ? (m + 1) % 60 : (m + 59) % 60;
              m_t[i] = m * 60 + s;
            end
          end
          M_RUN: begin
            if (tick) begin
              m_t[i] = m_dq[i] ? (m_t[i] + 3599) % 3600 : (m_t[i] + 1) % 3600;
              if (m_t[i] == 0) begin
                m_dn[i] = 1'b1;
                if (m_dq[i] && i == 0) m_st[i] = M_DONE;
              end
            end
            if (start_stop && m_st[i] == M_RUN) m_st[i] = M_PAUSE;
          end
          M_PAUSE: if (start_stop) m_st[i] = M_RUN;
          default: if (start_stop) m_st[i] = M_IDLE;
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("digits", d0, exp_dig(m_t[0]));
    chk("running", 16'(run0), 16'(m_st[0] == M_RUN));
    chk("done", 16'(done0), 16'(m_dn[0]));
    chk("digits_wrap", d1, exp_dig(m_t[1]));
    chk("running_wrap", 16'(run1), 16'(m_st[1] == M_RUN));
    chk("done_wrap", 16'(done1), 16'(m_dn[1]));
  endtask

  // one clock: drive pulses, advance model on the edge, compare just after it
  task automatic cyc(input bit tk, input bit ss, input bit clr, input bit in, input bit de);
    tick = tk; start_stop = ss; clear = clr; inc = in; dec = de;
    @(posedge clk);
    model_step();
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; inc = 1'b0; dec = 1'b0;
    compare_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_digits", d0, 16'h0000);
    chk("reset_running", 16'(run0), 16'h0);
    chk("reset_done", 16'(done0), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // up-count carries
    dir = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("up_running", 16'(run0), 16'h1);
    ticks(58);
    chk("up_0058", d0, 16'h0058);
    ticks(1);
    chk("up_0059", d0, 16'h0059);
    ticks(1);
    chk("up_0100", d0, 16'h0100);

    // minute adjust in IDLE
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("dec_wrap_5900", d0, 16'h5900);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("inc_dec_hold", d0, 16'h5900);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("inc_wrap_0000", d0, 16'h0000);
    dir = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("down_zero_stays_idle", 16'(run0), 16'h0);

    // down-count borrows to terminal
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    dir = 1'b0;
    ticks(1);
    chk("down_0059", d0, 16'h0059);
    ticks(58);
    chk("down_0001", d0, 16'h0001);
    ticks(1);
    chk("down_0000", d0, 16'h0000);
    chk("down_done_pulse", 16'(done0), 16'h1);
    chk("down_done_state", 16'(run0), 16'h0);
    ticks(1);
    chk("done_hold", d0, 16'h0000);
    chk("done_one_cycle", 16'(done0), 16'h0);
    chk("wrap_5959", d1, 16'h5959);
    chk("wrap_no_done", 16'(done1), 16'h0);
    chk("wrap_running", 16'(run1), 16'h1);

    // 59:59 up wrap
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(59);
    chk("up_5959", d0, 16'h5959);
    ticks(1);
    chk("up_wrap_0000", d0, 16'h0000);
    chk("up_wrap_done", 16'(done0), 16'h1);
    chk("up_wrap_running", 16'(run0), 16'h1);

    // pause and priority
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(10);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tick_ss_0011", d0, 16'h0011);
    chk("tick_ss_paused", 16'(run0), 16'h0);
    ticks(3);
    chk("pause_hold", d0, 16'h0011);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("clear_tick", d0, 16'h0000);

    // asynchronous reset mid-count at 12:34
    repeat (12) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(34);
    chk("pre_reset_1234", d0, 16'h1234);
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("async_reset_digits", d0, 16'h0000);
    chk("async_reset_running", 16'(run0), 16'h0);
    chk("async_reset_done", 16'(done0), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);
    chk("no_resume_without_ss", d0, 16'h0000);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      dir = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_time_core.md
# stopwatch_time_core

Sequential MM:SS time register for the stopwatch. It consumes the 1 Hz tick and the user control pulses, and steps four BCD digits up or down with carry and borrow across digit boundaries. It runs a run/pause/done state machine and drives the digit values to the display path. It is the state-holding counterpart to the combinational per-digit add/subtract logic: it issues the step requests and latches the results.

## Interface
- `DOWN_STOP_AT_ZERO`, default 1: when 1, a down-count that reaches 00:00 enters DONE. When 0, it wraps to 59:59 and keeps running.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle 1 Hz enable from the prescaler.
- `start_stop` in 1: one-cycle pulse that toggles run/pause.
- `clear` in 1: one-cycle pulse that zeroes the time and returns to IDLE.
- `dir` in 1: 0 = count up, 1 = count down. Captured on the IDLE→RUN transition only.
- `inc` in 1: one-cycle pulse that adds one minute while in IDLE.
- `dec` in 1: one-cycle pulse that subtracts one minute while in IDLE.
- `sec_ones` out 4: BCD 0–9.
- `sec_tens` out 4: BCD 0–5.
- `min_ones` out 4: BCD 0–9.
- `min_tens` out 4: BCD 0–5.
- `running` out 1: high while the state is RUN.
- `done` out 1: one-cycle pulse at terminal count.

## Operation
- **States:**
  - IDLE is the reset state.
  - RUN, PAUSE and DONE complete the state set.
- **Reset:**
  - All digits are 0 and the state is IDLE.
  - `running`=0, `done`=0, latched direction = up.
- **IDLE:**
  - `inc`/`dec` adjust minutes by ±1, wrapping 59↔00. Seconds are untouched.
  - `start_stop` latches `dir` and moves to RUN.
  - Exception: if `dir`=1 and the time is 00:00, the state stays IDLE.
- **RUN, on `tick`, count up:**
  - `sec_ones` 9→0 carries into `sec_tens`; `sec_tens` 5→0 carries into `min_ones`, and so on up the chain.
  - At 59:59 the time wraps to 00:00, `done` pulses, and the state stays RUN.
- **RUN, on `tick`, count down:**
  - `sec_ones` 0→9 borrows from `sec_tens`; `sec_tens` 0→5 borrows from `min_ones`, and so on.
  - Reaching 00:00 pulses `done` and enters DONE when `DOWN_STOP_AT_ZERO`=1.
  - When `DOWN_STOP_AT_ZERO`=0, the next tick after 00:00 gives 59:59 with no `done` pulse.
- **RUN, on `start_stop`:** go to PAUSE.
- **PAUSE:**
  - Digits hold; `tick`, `inc` and `dec` are ignored.
  - `start_stop` returns to RUN with the latched direction unchanged.
- **DONE:**
  - Digits hold at 00:00.
  - `start_stop` or `clear` returns to IDLE.
- **`clear`:** from any state, zeroes all digits and goes to IDLE next cycle.
- **Priority, highest first:** `clear` > `tick` > `start_stop` > `inc`/`dec`.
- **Simultaneous events:**
  - `tick` and `start_stop` together in RUN: the step is applied and the state goes to PAUSE.
  - `inc` and `dec` together: no change.
  - `dir` changes outside the IDLE→RUN edge have no effect.

## Timing
- All outputs are registered and change only on a `clk` edge or on `rst_n` assertion.
- Digit update latency: outputs show the new value 1 cycle after the `tick` cycle.
- `done` is high for exactly 1 cycle, in the same cycle the terminal digit values appear.
- `running` follows the state register with no added latency.
- Inputs are synchronous pulses. Synchronization and debouncing happen upstream.
- Asserting `rst_n` mid-count drops outputs to reset values immediately. Counting resumes only via `start_stop` after release.

## Structure
- Package `stopwatch_pkg` holds:
  - the `sw_state_t` enum (IDLE, RUN, PAUSE, DONE);
  - the 4-bit `bcd_t` typedef;
  - constants `SEC_ONES_MAX`=9, `SEC_TENS_MAX`=5, `MIN_ONES_MAX`=9, `MIN_TENS_MAX`=5.
- Sub-module `bcd_digit_step` is combinational, instantiated 4× in a ripple chain:
  - inputs: digit, max, step enable, direction;
  - outputs: next digit, carry/borrow.
- The FSM, direction latch and digit registers live in the top level.

## Test plan
- **Reset value:** assert `rst_n`=0 mid-RUN at 12:34 → outputs 00:00, `running`=0, `done`=0 immediately.
- **Up-count carry:** up from 00:58, 2 ticks → 00:59 then 01:00. From 59:59, 1 tick → 00:00, `done` for 1 cycle, `running` stays 1.
- **Down-count borrow:** down from 01:00, 1 tick → 00:59. From 00:01, 1 tick → 00:00, `done` pulse, state DONE, `running`=0. Further ticks → no change.
- **Minute adjust and zero start:**
  - In IDLE, `dec` at 00:00 → 59:00.
  - `inc` and `dec` in the same cycle → unchanged.
  - `start_stop` with `dir`=1 at 00:00 → stays IDLE.
- **Pause and priority:**
  - `tick`+`start_stop` in the same cycle at 00:10 (up) → 00:11 and PAUSE.
  - Ticks in PAUSE → hold.
  - `clear`+`tick` in the same cycle → 00:00 and IDLE.
- **Wrap parameter:** with `DOWN_STOP_AT_ZERO`=0, down at 00:00 in RUN, 1 tick → 59:59, no `done`, `running`=1.
